pipemem_stage: RTL and testbench

PIPEMEM_STAGE -- requirements
Module: pipemem_stage

---
 rtl/pipemem_stage_pkg.sv | 26 ++
 rtl/pipemem_io.sv | 47 ++++
 rtl/pipemem_stage.sv | 150 +++++++++++++++
 tb/tb_pipemem_stage.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pipemem_stage_pkg.sv
// Shared pipeline definitions: MEM-stage FSM encoding, I/O port addresses,
// and small address/counter helpers.
package pipemem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] IO_OUT_ADDR_DEF = 32'h0000_0080;
  localparam logic [31:0] IO_IN_ADDR_DEF  = 32'h0000_00C0;

  localparam int CNT_W = 8;

  // Word-aligned form of a byte address
  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  // Saturating increment; the wait counter must never wrap
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/pipemem_io.sv
// Memory-mapped I/O: address decode for the output/input ports and the
// output port register. Accesses here never touch the data memory.
module pipemem_io
  import pipemem_stage_pkg::*;
#(
  parameter logic [31:0] IO_OUT_ADDR = IO_OUT_ADDR_DEF,
  parameter logic [31:0] IO_IN_ADDR  = IO_IN_ADDR_DEF
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        i_wr_en,
  input  logic        i_rd_en,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_in_port,
  output logic        o_hit,
  output logic [31:0] o_rdata,
  output logic [31:0] o_out_port
);

  logic [31:0] w_waddr;
  logic        w_hit_out;
  logic        w_hit_in;
  logic [31:0] r_out_port;

  assign w_waddr    = word_addr(i_addr);
  assign w_hit_out  = (w_waddr == IO_OUT_ADDR);
  assign w_hit_in   = (w_waddr == IO_IN_ADDR);
  assign o_hit      = w_hit_out | w_hit_in;
  assign o_out_port = r_out_port;

  // Output port register, written by a store to IO_OUT_ADDR
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                   r_out_port <= 32'h0;
    else if (i_wr_en && w_hit_out) r_out_port <= i_wdata;
  end

  // Combinational read mux; zero unless a load hits a port
  always_comb begin
    o_rdata = 32'h0;
    if (i_rd_en) begin
      if (w_hit_in)       o_rdata = i_in_port;
      else if (w_hit_out) o_rdata = r_out_port;
    end
  end

endmodule

// File: rtl/pipemem_stage.sv
// MEM pipeline stage: stalls the pipeline around a req/ack data-memory
// handshake with timeout, and services I/O port accesses with zero stall.
module pipemem_stage
  import pipemem_stage_pkg::*;
#(
  parameter int          TIMEOUT     = 15,
  parameter logic [31:0] IO_OUT_ADDR = IO_OUT_ADDR_DEF,
  parameter logic [31:0] IO_IN_ADDR  = IO_IN_ADDR_DEF
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        mwmem,
  input  logic        mm2reg,
  input  logic [31:0] malu,
  input  logic [31:0] mb,
  input  logic [31:0] in_port0,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] mmo,
  output logic        mem_stall,
  output logic [31:0] out_port0,
  output logic        bus_err
);

  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_inc;
  logic             r_mem_req, r_mem_we, r_bus_err;
  logic [31:0]      r_mem_addr, r_mem_wdata, r_rdq;

  logic        w_store, w_load, w_access, w_io_hit, w_mem_access;
  logic        w_stall, w_start, w_ack_take, w_abort, w_timeout;
  logic [31:0] w_io_rdata;

  // Store wins when both enables are set
  assign w_store      = mwmem;
  assign w_load       = mm2reg & ~mwmem;
  assign w_access     = mwmem | mm2reg;
  assign w_mem_access = w_access & ~w_io_hit;

  assign w_cnt_inc = sat_inc(r_cnt);
  assign w_timeout = (w_cnt_inc >= TO_LIMIT);

  // Port writes only happen from IDLE so a stalled instruction never rewrites
  pipemem_io #(
    .IO_OUT_ADDR (IO_OUT_ADDR),
    .IO_IN_ADDR  (IO_IN_ADDR)
  ) u_io (
    .clock      (clock),
    .resetn     (resetn),
    .i_wr_en    (w_store && (r_state == IDLE)),
    .i_rd_en    (w_load),
    .i_addr     (malu),
    .i_wdata    (mb),
    .i_in_port  (in_port0),
    .o_hit      (w_io_hit),
    .o_rdata    (w_io_rdata),
    .o_out_port (out_port0)
  );

  // FSM state register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state and handshake control
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_start     = 1'b0;
    w_ack_take  = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_mem_access) begin
          w_stall     = 1'b1;
          w_start     = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        w_stall = 1'b1;
        if (mem_ack) begin
          w_ack_take  = 1'b1;
          w_state_nxt = DONE;
        end else if (w_timeout) begin
          w_abort     = 1'b1;
          w_state_nxt = DONE;
        end
      end
      // Pipeline advances on this edge; never reissue the same access
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request registers, read-data capture, wait counter and sticky error
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'h0;
      r_mem_wdata <= 32'h0;
      r_rdq       <= 32'h0;
      r_cnt       <= '0;
      r_bus_err   <= 1'b0;
    end else begin
      if (w_start) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= w_store;
        r_mem_addr  <= word_addr(malu);
        r_mem_wdata <= mb;
        r_cnt       <= '0;
      end
      if (r_state == BUSY && !mem_ack) r_cnt <= w_cnt_inc;
      if (w_ack_take) begin
        r_rdq     <= mem_rdata;
        r_mem_req <= 1'b0;
      end
      if (w_abort) begin
        r_rdq     <= 32'h0;
        r_mem_req <= 1'b0;
        r_bus_err <= 1'b1;
      end
    end
  end

  // Load result: captured data in DONE, port data for I/O loads, else zero
  always_comb begin
    mmo = 32'h0;
    if (resetn) begin
      if (r_state == DONE && w_load)                mmo = r_rdq;
      else if (r_state == IDLE && w_io_hit)         mmo = w_io_rdata;
    end
  end

  assign mem_stall = resetn & w_stall;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_pipemem_stage.sv
// Directed plus randomized checks of pipemem_stage against a transaction-level
// model: each access predicts stall count, request fields, result and port state.
module tb_pipemem_stage;

  localparam int          TO      = 15;
  localparam logic [31:0] IO_OUT  = 32'h0000_0080;
  localparam logic [31:0] IO_IN   = 32'h0000_00C0;

  logic        clock = 1'b0;
  logic        resetn;
  logic        mwmem, mm2reg, mem_ack;
  logic [31:0] malu, mb, in_port0, mem_rdata;
  logic        mem_req, mem_we, mem_stall, bus_err;
  logic [31:0] mem_addr, mem_wdata, mmo, out_port0;

  int n_vec = 0;
  int n_err = 0;

  // Model state
  logic [31:0] m_out  = 32'h0;
  logic        m_berr = 1'b0;

  pipemem_stage #(.TIMEOUT(TO)) dut (
    .clock(clock), .resetn(resetn), .mwmem(mwmem), .mm2reg(mm2reg),
    .malu(malu), .mb(mb), .in_port0(in_port0), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mmo(mmo),
    .mem_stall(mem_stall), .out_port0(out_port0), .bus_err(bus_err)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_io(input logic [31:0] a);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    return (w == IO_OUT) || (w == IO_IN);
  endfunction

  task automatic idle_inputs();
    mwmem = 0; mm2reg = 0; mem_ack = 0; malu = $urandom; mb = $urandom;
    mem_rdata = $urandom;
  endtask

  // Memory access; ack_k = BUSY cycle (1-based) in which ack is driven.
  // ack_k > TO means no ack inside the timeout window.
  task automatic do_mem(input string tag, input bit st, input bit ld,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] rd, input int ack_k);
    int  stalls, exp_stalls;
    bit  done, timed_out, req_ok;
    logic [31:0] exp_mmo;
    timed_out  = (ack_k > TO);
    exp_stalls = timed_out ? TO + 1 : ack_k + 1;
    exp_mmo    = (ld && !st && !timed_out) ? rd : 32'h0;
    if (timed_out) m_berr = 1'b1;
    mwmem = st; mm2reg = ld; malu = addr; mb = data;
    stalls = 0; done = 0; req_ok = 1;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c == ack_k) begin mem_ack = 1; mem_rdata = rd; end
      else begin mem_ack = 0; mem_rdata = $urandom; end
      @(negedge clock);
      if (mem_stall) begin
        stalls++;
        if (c > 0 && mem_req !== 1'b1) req_ok = 0;
        if (c == 0 && mem_req !== 1'b0) req_ok = 0;
        @(posedge clock); #1;
      end else done = 1;
    end
    chk({tag, ".done"},   32'(done), 32'd1);
    chk({tag, ".stalls"}, stalls, exp_stalls);
    chk({tag, ".req_in_busy"}, 32'(req_ok), 32'd1);
    chk({tag, ".req_done"}, 32'(mem_req), 32'd0);
    chk({tag, ".addr"},   mem_addr, addr & 32'hFFFF_FFFC);
    chk({tag, ".we"},     32'(mem_we), 32'(st));
    chk({tag, ".wdata"},  mem_wdata, data);
    chk({tag, ".mmo"},    mmo, exp_mmo);
    chk({tag, ".bus_err"}, 32'(bus_err), 32'(m_berr));
    @(posedge clock); #1;
    idle_inputs();
    @(negedge clock);
    chk({tag, ".idle_stall"}, 32'(mem_stall), 32'd0);
    chk({tag, ".idle_req"},   32'(mem_req), 32'd0);
    @(posedge clock); #1;
  endtask

  // I/O access: zero stall, no mem_req, combinational read
  task automatic do_io(input string tag, input bit st, input logic [31:0] addr,
                       input logic [31:0] data, input logic [31:0] inp);
    logic [31:0] exp_mmo;
    logic [31:0] w;
    w = addr & 32'hFFFF_FFFC;
    exp_mmo = 32'h0;
    if (!st) exp_mmo = (w == IO_IN) ? inp : m_out;
    mwmem = st; mm2reg = !st; malu = addr; mb = data; in_port0 = inp;
    #1;
    chk({tag, ".mmo"}, mmo, exp_mmo);
    @(negedge clock);
    chk({tag, ".stall"}, 32'(mem_stall), 32'd0);
    chk({tag, ".req"},   32'(mem_req), 32'd0);
    @(posedge clock); #1;
    if (st && w == IO_OUT) m_out = data;
    idle_inputs();
    chk({tag, ".out_port"}, out_port0, m_out);
  endtask

  initial begin
    idle_inputs();
    in_port0 = 32'h0;
    resetn = 0;
    #12;
    chk("rst.req",   32'(mem_req), 32'd0);
    chk("rst.we",    32'(mem_we), 32'd0);
    chk("rst.addr",  mem_addr, 32'h0);
    chk("rst.wdata", mem_wdata, 32'h0);
    chk("rst.out",   out_port0, 32'h0);
    chk("rst.berr",  32'(bus_err), 32'd0);
    mwmem = 1; malu = 32'h10;
    #1;
    chk("rst.stall_held", 32'(mem_stall), 32'd0);
    mwmem = 0; mm2reg = 1; malu = 32'hC0; in_port0 = 32'h77;
    #1;
    chk("rst.mmo_held", mmo, 32'h0);
    idle_inputs();
    @(negedge clock); resetn = 1;
    @(posedge clock); #1;

    do_mem("ld_basic", 0, 1, 32'h10, 32'h0, 32'hDEADBEEF, 1);
    do_mem("st_basic", 1, 0, 32'h13, 32'h1234, 32'h0, 3);
    do_io("io_st", 1, 32'h80, 32'h55, 32'h0);
    do_io("io_ld_in", 0, 32'hC0, 32'h0, 32'hA5);
    do_io("io_ld_out", 0, 32'h81, 32'h0, 32'h1);
    do_mem("both", 1, 1, 32'h20, 32'hCAFE, 32'hBAD0, 1);

    // Reset pulsed in the second BUSY cycle
    mm2reg = 1; malu = 32'h40;
    @(posedge clock); @(posedge clock); #1;
    resetn = 0; m_out = 32'h0; m_berr = 0;
    #1;
    chk("rstbusy.req",   32'(mem_req), 32'd0);
    chk("rstbusy.stall", 32'(mem_stall), 32'd0);
    chk("rstbusy.berr",  32'(bus_err), 32'd0);
    chk("rstbusy.out",   out_port0, 32'h0);
    @(negedge clock); resetn = 1; idle_inputs();
    @(posedge clock); #1;
    mem_ack = 1; mem_rdata = 32'h1111;
    @(negedge clock);
    chk("rstbusy.late_ack_req",   32'(mem_req), 32'd0);
    chk("rstbusy.late_ack_stall", 32'(mem_stall), 32'd0);
    @(posedge clock); #1; mem_ack = 0;

    // Timeout with an ack arriving one cycle too late
    do_mem("timeout", 0, 1, 32'h100, 32'h0, 32'h9999, TO + 1);
    do_mem("ack_at_limit", 0, 1, 32'h104, 32'h0, 32'h4242, TO);

    // Randomized mix
    for (int i = 0; i < 40; i++) begin
      int op;
      logic [31:0] a;
      op = $urandom_range(0, 5);
      a  = $urandom;
      if (is_io(a)) a = a ^ 32'h100;
      case (op)
        0: do_mem("r_ld", 0, 1, a, $urandom, $urandom, $urandom_range(1, TO + 2));
        1: do_mem("r_st", 1, 0, a, $urandom, $urandom, $urandom_range(1, TO + 2));
        2: do_mem("r_both", 1, 1, a, $urandom, $urandom, $urandom_range(1, 6));
        3: do_io("r_io_st", 1, IO_OUT | 32'($urandom_range(0, 3)), $urandom, $urandom);
        4: do_io("r_io_in", 0, IO_IN | 32'($urandom_range(0, 3)), $urandom, $urandom);
        default: do_io("r_io_out", 0, IO_OUT, $urandom, $urandom);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
